// File: rtl/pe_buf_pkg.sv
// Shared types, default sizes and helpers for the PE ifmap stream buffer.
package pe_buf_pkg;

  // Transfer state: wait for start, stream words to the PE, one idle drain cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_DEPTH     = 8;
  localparam int DEFAULT_LEN_WIDTH = 6;

  // A programmed length of zero still moves one word.
  function automatic logic [31:0] eff_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer and occupancy bookkeeping for a circular FIFO.
// The caller qualifies push/pop, so push never arrives while full without a pop,
// and pop never arrives while empty.
module fifo_ptr_ctrl #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;

  // Next pointers wrap naturally at DEPTH; occupancy moves only on unmatched push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == (ADDR_WIDTH+1)'(DEPTH));

endmodule

// File: rtl/ifmap_stream_buffer.sv
// First-word-fall-through ifmap FIFO feeding the PE, with a transfer-length
// counter that flags the last word of each transfer on end_signal.
// Optional sticky error flags: define IFMAP_STREAM_BUF_ERR_EN.
module ifmap_stream_buffer
  import pe_buf_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] xfer_len,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  output logic                 full,
  output logic [WIDTH-1:0]     dout,
  output logic                 valid,
  input  logic                 rd_en,
  output logic                 end_signal,
  output logic                 busy,
  output logic [ADDR_WIDTH:0]  count
`ifdef IFMAP_STREAM_BUF_ERR_EN
  ,
  output logic                 overflow_err,
  output logic                 underflow_err
`endif
);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  push, pop;

  // A pop frees a slot in the same cycle, so a push at full is legal alongside it.
  assign pop  = rd_en && valid;
  assign push = wr_en && (!full || pop);

  fifo_ptr_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .pop_i    (pop),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full)
  );

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the data array is deliberately not reset; occupancy gates every read of it.
    if (push) mem_q[wr_ptr] <= wr_data;
  end

  // Head word is presented only while the FIFO holds data; words are hidden outside STREAM.
  assign dout       = (count != '0) ? mem_q[rd_ptr] : '0;
  assign valid      = (state_q == STREAM) && (count != '0);
  assign end_signal = (state_q == STREAM) && valid && (rem_q == LEN_WIDTH'(1));
  assign busy       = (state_q != IDLE);

  // Transfer sequencing and remaining-word count.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          rem_d   = LEN_WIDTH'(eff_len(32'(xfer_len)));
        end
      end
      STREAM: begin
        if (pop) begin
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
          else                        rem_d   = rem_q - LEN_WIDTH'(1);
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and transfer counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

`ifdef IFMAP_STREAM_BUF_ERR_EN
  logic ovf_q, unf_q;
  logic err_clr, ovf_set, unf_set;

  assign err_clr = start && (state_q == IDLE);
  assign ovf_set = wr_en && full && !pop;
  assign unf_set = rd_en && !valid && (state_q == STREAM);

  // Sticky error flags; cleared by an accepted start, a same-cycle event still sets them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !err_clr) || ovf_set;
      unf_q <= (unf_q && !err_clr) || unf_set;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
`endif

endmodule

// File: tb/tb_ifmap_stream_buffer.sv
// Self-checking bench for ifmap_stream_buffer: hand-written vector table for a basic
// transfer, directed corner sequences, then randomized traffic against a queue model.
module tb_ifmap_stream_buffer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int LW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LW-1:0]    xfer_len;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             rd_en;
  logic             end_signal;
  logic             busy;
  logic [AW:0]      count;
`ifdef IFMAP_STREAM_BUF_ERR_EN
  logic             overflow_err;
  logic             underflow_err;
`endif

  always #5 clk = ~clk;

  ifmap_stream_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .xfer_len   (xfer_len),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .dout       (dout),
    .valid      (valid),
    .rd_en      (rd_en),
    .end_signal (end_signal),
    .busy       (busy),
    .count      (count)
`ifdef IFMAP_STREAM_BUF_ERR_EN
    ,
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
`endif
  );

  typedef struct packed {
    logic [AW:0]      count;
    logic             valid;
    logic [WIDTH-1:0] dout;
    logic             end_s;
    logic             busy;
    logic             full;
  } outs_t;

  typedef struct {
    logic             st;
    logic [LW-1:0]    len;
    logic             we;
    logic [WIDTH-1:0] wd;
    logic             re;
    outs_t            exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a word queue plus a transfer phase (0 idle, 1 streaming, 2 drain).
  logic [WIDTH-1:0] mq[$];
  int               m_phase;
  int               m_rem;

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_rem   = 0;
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    bit    v;
    v       = (m_phase == 1) && (mq.size() > 0);
    o.count = (AW+1)'(mq.size());
    o.valid = v;
    o.dout  = (mq.size() > 0) ? mq[0] : '0;
    o.end_s = v && (m_rem == 1);
    o.busy  = (m_phase != 0);
    o.full  = (mq.size() == DEPTH);
    return o;
  endfunction

  task automatic model_update(input logic st, input logic [LW-1:0] len, input logic we,
                              input logic [WIDTH-1:0] wd, input logic re);
    bit v, do_pop, do_push;
    v       = (m_phase == 1) && (mq.size() > 0);
    do_pop  = re && v;
    do_push = we && ((mq.size() < DEPTH) || do_pop);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(wd);
    case (m_phase)
      0: if (st) begin
           m_phase = 1;
           m_rem   = (len == 0) ? 1 : int'(len);
         end
      1: if (do_pop) begin
           if (m_rem == 1) m_phase = 2;
           else            m_rem   = m_rem - 1;
         end
      default: m_phase = 0;
    endcase
  endtask

  // One clock: drive at posedge+1, sample at negedge, advance model, return at next posedge+1.
  task automatic step(input logic st, input logic [LW-1:0] len, input logic we,
                      input logic [WIDTH-1:0] wd, input logic re,
                      output outs_t obs, output outs_t exp);
    start    = st;
    xfer_len = len;
    wr_en    = we;
    wr_data  = wd;
    rd_en    = re;
    exp      = model_outs();
    @(negedge clk);
    obs = {count, valid, dout, end_signal, busy, full};
    model_update(st, len, we, wd, re);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_outs(input string tag, input outs_t obs, input outs_t exp);
    check({tag, ".count"}, 32'(obs.count), 32'(exp.count));
    check({tag, ".valid"}, 32'(obs.valid), 32'(exp.valid));
    check({tag, ".dout"},  32'(obs.dout),  32'(exp.dout));
    check({tag, ".end"},   32'(obs.end_s), 32'(exp.end_s));
    check({tag, ".busy"},  32'(obs.busy),  32'(exp.busy));
    check({tag, ".full"},  32'(obs.full),  32'(exp.full));
  endtask

  outs_t last_obs;

  task automatic run(input string tag, input logic st, input logic [LW-1:0] len,
                     input logic we, input logic [WIDTH-1:0] wd, input logic re);
    outs_t o, e;
    step(st, len, we, wd, re, o, e);
    cmp_outs(tag, o, e);
    last_obs = o;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) run(tag, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic zero_inputs();
    start    = 1'b0;
    xfer_len = '0;
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
  endtask

  // Basic transfer: push 1,2,3; start len 3; pop every cycle; expected outputs per cycle.
  vec_t tbl[10];

  initial begin
    outs_t o, e;

    tbl[0] = '{st:0, len:0, we:0, wd:0, re:0, exp:'{count:0, valid:0, dout:0, end_s:0, busy:0, full:0}};
    tbl[1] = '{st:0, len:0, we:1, wd:1, re:0, exp:'{count:0, valid:0, dout:0, end_s:0, busy:0, full:0}};
    tbl[2] = '{st:0, len:0, we:1, wd:2, re:0, exp:'{count:1, valid:0, dout:1, end_s:0, busy:0, full:0}};
    tbl[3] = '{st:0, len:0, we:1, wd:3, re:0, exp:'{count:2, valid:0, dout:1, end_s:0, busy:0, full:0}};
    tbl[4] = '{st:1, len:3, we:0, wd:0, re:0, exp:'{count:3, valid:0, dout:1, end_s:0, busy:0, full:0}};
    tbl[5] = '{st:0, len:0, we:0, wd:0, re:1, exp:'{count:3, valid:1, dout:1, end_s:0, busy:1, full:0}};
    tbl[6] = '{st:0, len:0, we:0, wd:0, re:1, exp:'{count:2, valid:1, dout:2, end_s:0, busy:1, full:0}};
    tbl[7] = '{st:0, len:0, we:0, wd:0, re:1, exp:'{count:1, valid:1, dout:3, end_s:1, busy:1, full:0}};
    tbl[8] = '{st:0, len:0, we:0, wd:0, re:0, exp:'{count:0, valid:0, dout:0, end_s:0, busy:1, full:0}};
    tbl[9] = '{st:0, len:0, we:0, wd:0, re:0, exp:'{count:0, valid:0, dout:0, end_s:0, busy:0, full:0}};

    rst = 1'b0;
    zero_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].st, tbl[i].len, tbl[i].we, tbl[i].wd, tbl[i].re, o, e);
      cmp_outs($sformatf("basic[%0d]", i), o, tbl[i].exp);
    end

    // Full and wrap: 8 pushes fill, the 9th is dropped, 8 pops return data in order.
    for (int i = 0; i < DEPTH; i++) run("fill", 1'b0, '0, 1'b1, 4'(i + 5), 1'b0);
    run("push9", 1'b0, '0, 1'b1, 4'hD, 1'b0);
    check("full_after_8", 32'(last_obs.full), 32'd1);
    run("after_drop", 1'b0, '0, 1'b0, '0, 1'b0);
    check("count_after_drop", 32'(last_obs.count), 32'd8);
`ifdef IFMAP_STREAM_BUF_ERR_EN
    check("overflow_err", 32'(overflow_err), 32'd1);
`endif
    run("start8", 1'b1, 6'd8, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      run("wrap_pop", 1'b0, '0, 1'b0, '0, 1'b1);
      check($sformatf("wrap_dout[%0d]", i), 32'(last_obs.dout), 32'(i + 5));
      check($sformatf("wrap_end[%0d]", i), 32'(last_obs.end_s), (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end
    idle("wrap_tail", 2);

    // Simultaneous push and pop while full.
    for (int i = 0; i < DEPTH; i++) run("fill2", 1'b0, '0, 1'b1, 4'(i + 1), 1'b0);
    run("start8b", 1'b1, 6'd8, 1'b0, '0, 1'b0);
    run("simul", 1'b0, '0, 1'b1, 4'hA, 1'b1);
    check("simul_full", 32'(last_obs.full), 32'd1);
    run("simul_next", 1'b0, '0, 1'b0, '0, 1'b1);
    check("simul_count", 32'(last_obs.count), 32'd8);
    for (int i = 0; i < DEPTH - 2; i++) run("simul_pop", 1'b0, '0, 1'b0, '0, 1'b1);
    idle("simul_drain", 2);
    check("simul_left", 32'(last_obs.count), 32'd1);
    run("start1", 1'b1, 6'd1, 1'b0, '0, 1'b0);
    run("last_word", 1'b0, '0, 1'b0, '0, 1'b1);
    check("last_word_dout", 32'(last_obs.dout), 32'hA);
    check("last_word_end", 32'(last_obs.end_s), 32'd1);
    idle("last_drain", 2);

    // Surplus words stay for the next transfer.
    for (int i = 0; i < 5; i++) run("push5", 1'b0, '0, 1'b1, 4'(i + 1), 1'b0);
    run("start2", 1'b1, 6'd2, 1'b0, '0, 1'b0);
    run("sur_pop1", 1'b0, '0, 1'b0, '0, 1'b1);
    run("sur_pop2", 1'b0, '0, 1'b0, '0, 1'b1);
    check("sur_end2", 32'(last_obs.end_s), 32'd1);
    run("sur_drain", 1'b0, '0, 1'b0, '0, 1'b1);
    check("sur_drain_valid", 32'(last_obs.valid), 32'd0);
    check("sur_drain_count", 32'(last_obs.count), 32'd3);
    run("start3", 1'b1, 6'd3, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run("sur_pop", 1'b0, '0, 1'b0, '0, 1'b1);
      check($sformatf("sur_dout[%0d]", i), 32'(last_obs.dout), 32'(i + 3));
    end
    idle("sur_tail", 2);

    // Zero length behaves as one.
    run("z_push", 1'b0, '0, 1'b1, 4'h6, 1'b0);
    run("z_push", 1'b0, '0, 1'b1, 4'h7, 1'b0);
    run("z_start", 1'b1, 6'd0, 1'b0, '0, 1'b0);
    run("z_pop", 1'b0, '0, 1'b0, '0, 1'b1);
    check("zero_len_end", 32'(last_obs.end_s), 32'd1);
    run("z_drain", 1'b0, '0, 1'b0, '0, 1'b0);
    check("zero_len_left", 32'(last_obs.count), 32'd1);
    idle("z_tail", 1);

    // Mid-transfer asynchronous reset.
    for (int i = 0; i < 3; i++) run("r_push", 1'b0, '0, 1'b1, 4'(i + 9), 1'b0);
    run("r_start", 1'b1, 6'd4, 1'b0, '0, 1'b0);
    run("r_pop", 1'b0, '0, 1'b0, '0, 1'b1);
    run("r_pop", 1'b0, '0, 1'b0, '0, 1'b1);
    zero_inputs();
    #2 rst = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_dout",  32'(dout), 32'd0);
    check("arst_end",   32'(end_signal), 32'd0);
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_full",  32'(full), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    run("post_rst", 1'b0, '0, 1'b0, '0, 1'b0);
    check("post_rst_count", 32'(last_obs.count), 32'd0);
    check("post_rst_busy", 32'(last_obs.busy), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic             r_st, r_we, r_re;
      logic [LW-1:0]    r_len;
      logic [WIDTH-1:0] r_wd;
      r_st  = ($urandom_range(0, 9) == 0);
      r_len = LW'($urandom_range(0, 10));
      r_we  = ($urandom_range(0, 1) == 1);
      r_wd  = WIDTH'($urandom);
      r_re  = ($urandom_range(0, 9) < 6);
      run("rand", r_st, r_len, r_we, r_wd, r_re);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifmap_stream_buffer.md
Name: ifmap_stream_buffer

Overview:
- Upstream feeder for the PE ifmap path.
- A circular first-word-fall-through FIFO takes ifmap words from the global-buffer loader and presents them to the PE.
- The PE interface is inp_buf_ifmap, valid_ifmap and read_en_ifmap_buf; the block also generates end_signal.
- A transfer counter tracks a programmed transfer length so end_signal accompanies exactly the last word of the transfer.

Parameters:
- WIDTH, 4, ifmap word width; must match the PE datapath width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH), FIFO pointer width.
- LEN_WIDTH, 6, transfer-length counter width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous active-low reset; rst=0 clears all state immediately.
- start  in  1  one-cycle pulse that samples xfer_len and begins a transfer.
- xfer_len  in  LEN_WIDTH  number of words in this transfer; the value 0 is treated as 1.
- wr_en  in  1  loader push request.
- wr_data  in  WIDTH  loader word.
- full  out  1  FIFO full; the loader must not push unless a pop happens in the same cycle.
- dout  out  WIDTH  head word; drives the PE inp_buf_ifmap.
- valid  out  1  head word is valid; drives the PE valid_ifmap.
- rd_en  in  1  PE pop; driven by the PE read_en_ifmap_buf.
- end_signal  out  1  the head word is the last word of the transfer.
- busy  out  1  a transfer is in progress.
- count  out  ADDR_WIDTH+1  current occupancy.

Behaviour:
- Reset values: full=0, valid=0, end_signal=0, busy=0, count=0, dout=0. Pointers, counters and state are all cleared.
- Storage: DEPTH x WIDTH register array. rd_ptr and wr_ptr are ADDR_WIDTH wide and wrap modulo DEPTH. Occupancy counter has ADDR_WIDTH+1 bits.
- dout = mem[rd_ptr], combinational, with zero read latency. dout is 0 when the FIFO is empty.
- Push: wr_en && (!full || pop) writes mem[wr_ptr] and increments wr_ptr.
  - A push while full with no pop is dropped; state is unchanged.
- Pop: rd_en && valid increments rd_ptr. rd_en while !valid is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal when full and when count=1.
  - A word pushed into an empty FIFO appears on dout the next cycle. There is no same-cycle bypass.
- State machine IDLE / STREAM / DRAIN:
  - IDLE: valid is forced to 0 and pushes are accepted. start moves to STREAM and loads rem = max(xfer_len,1). busy=0.
  - STREAM: valid = (count != 0). Each pop decrements rem. When a pop occurs with rem==1, move to DRAIN. busy=1.
  - DRAIN: valid=0 for one cycle, then return to IDLE. Words beyond the transfer stay in the FIFO for the next transfer.
- end_signal = (state==STREAM) && valid && (rem==1). It is combinational and stays stable until the pop.
- start in STREAM or DRAIN is ignored.
- An asynchronous reset mid-transfer discards the FIFO contents and returns to IDLE. No end_signal is emitted.

Optional Feature:
- Macro: IFMAP_STREAM_BUF_ERR_EN.
- When defined, add outputs overflow_err and underflow_err, both 1-bit.
  - overflow_err is sticky and sets on a dropped push.
  - underflow_err is sticky and sets on rd_en while !valid in STREAM.
  - Both clear only on reset or on start.
- When not defined, the ports are absent and these events are silently ignored.

Decomposition:
- Shared package pe_buf_pkg holds:
  - the state enum (IDLE, STREAM, DRAIN);
  - default WIDTH and DEPTH constants;
  - a function computing the effective length max(len,1).
- One sub-module, fifo_ptr_ctrl: pointer and occupancy bookkeeping, producing wr_ptr, rd_ptr, count and full.
- The top level holds the storage array, the FSM and the transfer counter.

Test Plan:
- Basic transfer: reset, push 0x1,0x2,0x3, start with xfer_len=3, PE pops every cycle.
  - dout sequence is 1,2,3; end_signal is high only with 3; busy falls after DRAIN.
- Full and wrap: DEPTH=8, push 9 words with no pop.
  - full=1 after the 8th push; the 9th is dropped (overflow_err=1 if enabled).
  - Then pop 8 with xfer_len=8: data is returned in order across the wrap.
- Simultaneous push and pop at full: count stays 8, the new word comes out last, no drop.
- Surplus words: push 5, start with xfer_len=2.
  - end_signal with the 2nd word, valid=0 in DRAIN, count=3 remaining.
  - A second start with len=3 delivers the remaining 3.
- xfer_len=0: behaves as length 1; end_signal is asserted with the first word.
- Mid-transfer reset: rst low after 2 of 4 pops.
  - All outputs are 0 immediately (asynchronously); after reset release, count=0 and state is IDLE.
